// File: rtl/fill_rect_decode_engine_pkg.sv
// Shared graphics-engine constants: decode/generator state codes, opcodes, command word field positions.
// Latency: n/a (constants only).
// Backpressure: n/a.
package fill_rect_decode_engine_pkg;

    // Decode engine states; these exact codes are presented to the data generator
    localparam logic [4:0] ADDR_ST_IDLE           = 5'd0;
    localparam logic [4:0] ADDR_ST_FETCH_POS      = 5'd8;
    localparam logic [4:0] ADDR_ST_FETCH_DIM      = 5'd9;
    localparam logic [4:0] ADDR_ST_DECODE_STATE_B = 5'd10;
    localparam logic [4:0] ADDR_ST_WAIT_GEN       = 5'd11;

    // Data generator states as seen by the decode engine
    localparam logic [4:0] GEN_STATE_IDLE  = 5'd0;
    localparam logic [4:0] GEN_STATE_DRIVE = 5'd1;

    // Opcode that selects a fill-rect command
    localparam logic [3:0] OP_FILL_RECT_DFLT = 4'h1;

    // Word 0: opcode and colour (low half is don't-care)
    localparam int W0_OP_LSB = 28;
    localparam int W0_R_LSB  = 24;
    localparam int W0_G_LSB  = 20;
    localparam int W0_B_LSB  = 16;

    // Word 1: position
    localparam int W1_X_LSB  = 16;
    localparam int W1_Y_LSB  = 0;

    // Word 2: dimensions
    localparam int W2_WID_LSB = 16;
    localparam int W2_HGT_LSB = 0;

endpackage

// File: rtl/fill_rect_addr_calc.sv
// Rectangle start address: (y * ROW_STRIDE + x) mod 2^16 using shifts and adds only.
// Latency: combinational.
// Backpressure: none.
module fill_rect_addr_calc #(
    parameter int ROW_STRIDE = 240
) (
    input  logic [15:0] x_i,
    input  logic [15:0] y_i,
    output logic [15:0] addr_o
);

    generate
        if (ROW_STRIDE == 240) begin : g_stride_240
            // 240 = 256 - 16: one subtract instead of four adds
            assign addr_o = (y_i << 8) - (y_i << 4) + x_i;
        end else begin : g_stride_generic
            logic [15:0] acc;
            // Sum a shifted copy of y for every set bit of the constant stride
            always_comb begin
                acc = x_i;
                for (int i = 0; i < 16; i++) begin
                    if (ROW_STRIDE[i]) begin
                        acc = acc + (y_i << i);
                    end
                end
            end
            assign addr_o = acc;
        end
    endgenerate

endmodule

// File: rtl/fill_rect_decode_engine.sv
// Decodes 3-word fill-rect commands from the command FIFO and hands them to the data generator.
// Latency: 3 FIFO transfers, then DECODE_STATE_B on the next cycle; done pulses one cycle after generator returns idle.
// Backpressure: cmd_fifo_rtr high only in IDLE/FETCH_POS/FETCH_DIM; low rts stalls the current state.
module fill_rect_decode_engine
    import fill_rect_decode_engine_pkg::*;
#(
    parameter int         ROW_STRIDE   = 240,
    parameter logic [3:0] OP_FILL_RECT = OP_FILL_RECT_DFLT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_fifo_rts,
    output logic        cmd_fifo_rtr,
    input  logic [31:0] cmd_fifo_data,
    input  logic [4:0]  fill_rect_data_gen_eng_state,
    output logic [4:0]  addr_eng_state,
    output logic [15:0] init_addr,
    output logic [15:0] cmd_data_hgt,
    output logic [15:0] cmd_data_wid,
    output logic [3:0]  cmd_data_rval,
    output logic [3:0]  cmd_data_gval,
    output logic [3:0]  cmd_data_bval,
    output logic        cmd_done,
    output logic        cmd_err
);

    logic [4:0]  state_q, state_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [3:0]  r_q, g_q, b_q;
    logic [15:0] x_q, y_q, wid_q, hgt_q, init_addr_q;
    logic [15:0] addr_calc;
    logic        xfc;

    logic [3:0]  w0_op;
    logic [15:0] w2_wid, w2_hgt;

    assign w0_op  = cmd_fifo_data[W0_OP_LSB +: 4];
    assign w2_wid = cmd_fifo_data[W2_WID_LSB +: 16];
    assign w2_hgt = cmd_fifo_data[W2_HGT_LSB +: 16];

    // Ready only while fetching words; forced low during reset so nothing is popped
    assign cmd_fifo_rtr = !rst && ((state_q == ADDR_ST_IDLE) ||
                                   (state_q == ADDR_ST_FETCH_POS) ||
                                   (state_q == ADDR_ST_FETCH_DIM));
    assign xfc = cmd_fifo_rts && cmd_fifo_rtr;

    // Address uses the already-latched position, so it is ready when word 2 arrives
    fill_rect_addr_calc #(
        .ROW_STRIDE (ROW_STRIDE)
    ) u_addr_calc (
        .x_i    (x_q),
        .y_i    (y_q),
        .addr_o (addr_calc)
    );

    // Next-state and retire/error pulse decode
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ADDR_ST_IDLE: begin
                if (xfc) begin
                    if (w0_op == OP_FILL_RECT) begin
                        state_d = ADDR_ST_FETCH_POS;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ADDR_ST_FETCH_POS: begin
                if (xfc) begin
                    state_d = ADDR_ST_FETCH_DIM;
                end
            end
            ADDR_ST_FETCH_DIM: begin
                if (xfc) begin
                    // Empty rectangle retires without waking the generator
                    if ((w2_wid == 16'd0) || (w2_hgt == 16'd0)) begin
                        state_d = ADDR_ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ADDR_ST_DECODE_STATE_B;
                    end
                end
            end
            ADDR_ST_DECODE_STATE_B: begin
                if (fill_rect_data_gen_eng_state != GEN_STATE_IDLE) begin
                    state_d = ADDR_ST_WAIT_GEN;
                end
            end
            ADDR_ST_WAIT_GEN: begin
                if (fill_rect_data_gen_eng_state == GEN_STATE_IDLE) begin
                    state_d = ADDR_ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ADDR_ST_IDLE;
            end
        endcase
    end

    // State and pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ADDR_ST_IDLE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Field capture; fields only change on fetch transfers so they hold through generation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q         <= 4'd0;
            g_q         <= 4'd0;
            b_q         <= 4'd0;
            x_q         <= 16'd0;
            y_q         <= 16'd0;
            wid_q       <= 16'd0;
            hgt_q       <= 16'd0;
            init_addr_q <= 16'd0;
        end else if (xfc) begin
            if ((state_q == ADDR_ST_IDLE) && (w0_op == OP_FILL_RECT)) begin
                r_q <= cmd_fifo_data[W0_R_LSB +: 4];
                g_q <= cmd_fifo_data[W0_G_LSB +: 4];
                b_q <= cmd_fifo_data[W0_B_LSB +: 4];
            end
            if (state_q == ADDR_ST_FETCH_POS) begin
                x_q <= cmd_fifo_data[W1_X_LSB +: 16];
                y_q <= cmd_fifo_data[W1_Y_LSB +: 16];
            end
            if (state_q == ADDR_ST_FETCH_DIM) begin
                wid_q <= w2_wid;
                hgt_q <= w2_hgt;
                if ((w2_wid != 16'd0) && (w2_hgt != 16'd0)) begin
                    init_addr_q <= addr_calc;
                end
            end
        end
    end

    assign addr_eng_state = state_q;
    assign init_addr      = init_addr_q;
    assign cmd_data_wid   = wid_q;
    assign cmd_data_hgt   = hgt_q;
    assign cmd_data_rval  = r_q;
    assign cmd_data_gval  = g_q;
    assign cmd_data_bval  = b_q;
    assign cmd_done       = done_q;
    assign cmd_err        = err_q;

endmodule

// File: tb/tb_fill_rect_decode_engine.sv
// Randomized bench for fill_rect_decode_engine against a command-level reference model.
// Latency: n/a.
// Backpressure: FIFO rts is randomly withheld during fetches.
module tb_fill_rect_decode_engine;

    localparam int         ROW_STRIDE = 240;
    localparam logic [3:0] OP_FILL    = 4'h1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rts = 1'b0;
    logic        rtr;
    logic [31:0] data = 32'd0;
    logic [4:0]  gen = 5'd0;
    logic [4:0]  state;
    logic [15:0] addr, hgt, wid;
    logic [3:0]  rv, gv, bv;
    logic        done, err;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: what the outputs should currently hold
    logic [3:0]  exp_r = 4'd0, exp_g = 4'd0, exp_b = 4'd0;
    logic [15:0] exp_wid = 16'd0, exp_hgt = 16'd0, exp_addr = 16'd0;

    fill_rect_decode_engine #(
        .ROW_STRIDE   (ROW_STRIDE),
        .OP_FILL_RECT (OP_FILL)
    ) dut (
        .clk                          (clk),
        .rst                          (rst),
        .cmd_fifo_rts                 (rts),
        .cmd_fifo_rtr                 (rtr),
        .cmd_fifo_data                (data),
        .fill_rect_data_gen_eng_state (gen),
        .addr_eng_state               (state),
        .init_addr                    (addr),
        .cmd_data_hgt                 (hgt),
        .cmd_data_wid                 (wid),
        .cmd_data_rval                (rv),
        .cmd_data_gval                (gv),
        .cmd_data_bval                (bv),
        .cmd_done                     (done),
        .cmd_err                      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_fields(input string tag);
        check({tag, "_r"}, {28'd0, rv}, {28'd0, exp_r});
        check({tag, "_g"}, {28'd0, gv}, {28'd0, exp_g});
        check({tag, "_b"}, {28'd0, bv}, {28'd0, exp_b});
        check({tag, "_wid"}, {16'd0, wid}, {16'd0, exp_wid});
        check({tag, "_hgt"}, {16'd0, hgt}, {16'd0, exp_hgt});
        check({tag, "_addr"}, {16'd0, addr}, {16'd0, exp_addr});
    endtask

    // Assert reset mid-cycle; every output must clear without waiting for a clock edge
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        exp_r = 4'd0; exp_g = 4'd0; exp_b = 4'd0;
        exp_wid = 16'd0; exp_hgt = 16'd0; exp_addr = 16'd0;
        check("rst_state", {27'd0, state}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rtr", {31'd0, rtr}, 32'd0);
        check_fields("rst");
        gen = 5'd0;
        rts = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_state", {27'd0, state}, 32'd0);
            check("post_rst_no_done", {31'd0, done}, 32'd0);
        end
    endtask

    // Offer one word, optionally with random gaps in rts, until it is transferred
    task automatic send_word(input logic [31:0] w, input bit stall);
        bit took = 1'b0;
        for (int i = 0; i < 64 && !took; i++) begin
            @(negedge clk);
            if (stall && ($urandom_range(0, 2) == 0)) begin
                rts  = 1'b0;
                data = $urandom;
            end else begin
                rts  = 1'b1;
                data = w;
            end
            took = rts && rtr;
            @(posedge clk);
        end
        #1;
        rts  = 1'b0;
        data = $urandom;
        check("xfc_taken", {31'd0, took}, 32'd1);
    endtask

    // abort: 0 = run to completion, 1 = reset during fetch, 2 = reset in WAIT_GEN
    task automatic run_cmd(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                           input bit stall, input int abort);
        logic [3:0] op;
        int xi, yi;
        op = w0[31:28];
        send_word(w0, stall);
        @(negedge clk);
        if (op != OP_FILL) begin
            check("err_pulse", {31'd0, err}, 32'd1);
            check("err_no_done", {31'd0, done}, 32'd0);
            check("err_state", {27'd0, state}, 32'd0);
            check("err_rtr", {31'd0, rtr}, 32'd1);
            check_fields("err_keep");
            @(negedge clk);
            check("err_one_shot", {31'd0, err}, 32'd0);
            return;
        end
        exp_r = w0[27:24];
        exp_g = w0[23:20];
        exp_b = w0[19:16];
        check("pos_state", {27'd0, state}, 32'd8);
        check("pos_rtr", {31'd0, rtr}, 32'd1);
        send_word(w1, stall);
        @(negedge clk);
        check("dim_state", {27'd0, state}, 32'd9);
        if (abort == 1) begin
            do_reset();
            return;
        end
        send_word(w2, stall);
        exp_wid = w2[31:16];
        exp_hgt = w2[15:0];
        @(negedge clk);
        if (exp_wid == 16'd0 || exp_hgt == 16'd0) begin
            check("zero_state", {27'd0, state}, 32'd0);
            check("zero_done", {31'd0, done}, 32'd1);
            check("zero_no_err", {31'd0, err}, 32'd0);
            check_fields("zero");
            @(negedge clk);
            check("zero_done_one_shot", {31'd0, done}, 32'd0);
            check("zero_stay_idle", {27'd0, state}, 32'd0);
            return;
        end
        xi = int'(w1[31:16]);
        yi = int'(w1[15:0]);
        exp_addr = 16'((yi * ROW_STRIDE + xi) % 65536);
        check("decode_state", {27'd0, state}, 32'd10);
        check("decode_rtr", {31'd0, rtr}, 32'd0);
        check_fields("decode");
        repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            check("hold_decode", {27'd0, state}, 32'd10);
        end
        gen = 5'($urandom_range(1, 31));
        @(negedge clk);
        check("wait_state", {27'd0, state}, 32'd11);
        if (abort == 2) begin
            do_reset();
            return;
        end
        repeat ($urandom_range(0, 4)) begin
            gen = 5'($urandom_range(1, 31));
            @(negedge clk);
            check("hold_wait", {27'd0, state}, 32'd11);
            check("hold_wait_no_done", {31'd0, done}, 32'd0);
            check_fields("hold_wait");
        end
        gen = 5'd0;
        @(negedge clk);
        check("retire_state", {27'd0, state}, 32'd0);
        check("retire_done", {31'd0, done}, 32'd1);
        check("retire_no_err", {31'd0, err}, 32'd0);
        check_fields("retire");
        @(negedge clk);
        check("retire_one_shot", {31'd0, done}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] w0, w1, w2;
        do_reset();

        // Directed reference command, no stalls
        run_cmd(32'h1A5C0000, 32'h00050002, 32'h00040003, 1'b0, 0);

        // Unknown opcode dropped, then a good command
        run_cmd(32'h7123ABCD, 32'h0, 32'h0, 1'b0, 0);
        run_cmd(32'h1A5C0000, 32'h00050002, 32'h00040003, 1'b0, 0);

        // Zero-size rectangles
        run_cmd(32'h13450000, 32'h00010001, 32'h00000007, 1'b0, 0);
        run_cmd(32'h1F0F0000, 32'h00030004, 32'h00090000, 1'b1, 0);

        // Address wrap
        run_cmd(32'h11110000, 32'h0010FFFF, 32'h00010001, 1'b0, 0);

        // Reset while waiting on the generator, and during a stalled fetch
        run_cmd(32'h12340000, 32'h00200030, 32'h00050005, 1'b1, 2);
        run_cmd(32'h19870000, 32'h00110022, 32'h00020002, 1'b1, 1);

        // Randomized commands with FIFO stalls
        for (int n = 0; n < 30; n++) begin
            w0 = $urandom;
            w0[31:28] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : OP_FILL;
            w1 = $urandom;
            w2 = $urandom;
            if ($urandom_range(0, 6) == 0) w2[31:16] = 16'd0;
            if ($urandom_range(0, 6) == 0) w2[15:0]  = 16'd0;
            run_cmd(w0, w1, w2, 1'($urandom_range(0, 1)), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fill_rect_decode_engine.md
FILL_RECT_DECODE_ENGINE -- requirements
Module: fill_rect_decode_engine

Interface
REQ-001 Parameter ROW_STRIDE, default 240: frame-buffer address increment per pixel row.
REQ-002 Parameter OP_FILL_RECT, default 4'h1: opcode value that selects a fill-rect command.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 cmd_fifo_rts  input  1  command FIFO has a word available.
REQ-006 cmd_fifo_rtr  output  1  block accepts a command word; a transfer (xfc) occurs when rts and rtr are both high at a clock edge.
REQ-007 cmd_fifo_data  input  32  command word.
REQ-008 fill_rect_data_gen_eng_state  input  5  current state of the downstream data generator.
REQ-009 addr_eng_state  output  5  decode state, presented to the data generator.
REQ-010 init_addr  output  16  rectangle start address.
REQ-011 cmd_data_hgt, cmd_data_wid  output  16 each  rectangle height and width in pixels.
REQ-012 cmd_data_rval, cmd_data_gval, cmd_data_bval  output  4 each  fill colour.
REQ-013 cmd_done  output  1  one-cycle pulse when a command retires.
REQ-014 cmd_err  output  1  one-cycle pulse when an unknown opcode is dropped.

Function
REQ-015 Command word 0 SHALL be laid out as [31:28] opcode, [27:24] r, [23:20] g, [19:16] b; bits [15:0] are ignored.
REQ-016 Command word 1 SHALL be laid out as [31:16] x, [15:0] y.
REQ-017 Command word 2 SHALL be laid out as [31:16] wid, [15:0] hgt.
REQ-018 States and addr_eng_state encodings SHALL be: IDLE=0, FETCH_POS=8, FETCH_DIM=9, DECODE_STATE_B=10, WAIT_GEN=11.
REQ-019 cmd_fifo_rtr SHALL be high in IDLE, FETCH_POS and FETCH_DIM, low in all other states, and low while rst is high; it SHALL be decoded combinationally from state.
REQ-020 IDLE: on an xfc with opcode == OP_FILL_RECT, latch r, g and b and go to FETCH_POS.
REQ-021 IDLE: on an xfc with any other opcode, pulse cmd_err next cycle and stay in IDLE (word dropped).
REQ-022 FETCH_POS: on an xfc, latch x and y and go to FETCH_DIM.
REQ-023 FETCH_DIM: on an xfc, latch wid and hgt.
REQ-024 FETCH_DIM xfc, wid or hgt zero: go to IDLE and pulse cmd_done; the data generator SHALL NOT be started.
REQ-025 FETCH_DIM xfc, both nonzero: register init_addr = (y*ROW_STRIDE + x) mod 2^16 on the same edge and go to DECODE_STATE_B.
REQ-026 The multiply SHALL be implemented by shift-and-add (y<<8 minus y<<4 for the default ROW_STRIDE); no generic multiplier.
REQ-027 DECODE_STATE_B: hold until fill_rect_data_gen_eng_state != GEN_STATE_IDLE (0), then go to WAIT_GEN.
REQ-028 WAIT_GEN: hold until fill_rect_data_gen_eng_state == GEN_STATE_IDLE, then go to IDLE and pulse cmd_done.
REQ-029 init_addr and all cmd_data_* outputs SHALL remain stable from entry to DECODE_STATE_B until the return to IDLE.
REQ-030 Without FIFO stalls, command latency SHALL be 3 xfc cycles, then DECODE_STATE_B on the cycle after the third xfc.
REQ-031 cmd_fifo_rts deasserting mid-command SHALL stall the current state with no field corruption.
REQ-032 cmd_done and cmd_err SHALL never be high in the same cycle.

Reset
REQ-033 rst high SHALL immediately force: state IDLE, addr_eng_state 0, init_addr 0, all cmd_data_* 0, cmd_done 0, cmd_err 0, cmd_fifo_rtr 0.
REQ-034 Reset asserted mid-command SHALL abandon the command; no cmd_done is issued for it.

Structure
REQ-035 Decode-state encodings, GEN_STATE_IDLE=0, GEN_STATE_DRIVE=1, OP_FILL_RECT and the command field bit positions SHALL live in a shared graphics-engine constants package, also used by the data generator.
REQ-036 The address computation SHALL be a sub-module, fill_rect_addr_calc (combinational, x/y in, 16-bit address out).

Verification
REQ-037 Scenario: words 0x1A5C0000, 0x00050002, 0x00040003 back-to-back -> addr_eng_state=10 with init_addr=485 (0x01E5), wid=4, hgt=3, r=A, g=5, b=C.
REQ-038 Scenario: generator state 0->1 (held) ->0 -> state sequence 10, 11, 0, with cmd_done high exactly one cycle after the 1->0 transition.
REQ-039 Scenario: word 0 = 0x7xxxxxxx -> cmd_err one pulse; state stays 0; the next valid command decodes correctly.
REQ-040 Scenario: wid=0 -> cmd_done pulse and return to IDLE; addr_eng_state never equals 10.
REQ-041 Scenario: y=0xFFFF, x=0x0010 -> init_addr = (65535*240+16) mod 65536 = 0xFF20.
REQ-042 Scenario: rst asserted while in WAIT_GEN, and separately while cmd_fifo_rts toggles randomly during fetch -> all outputs 0 immediately on reset; stalls do not corrupt the latched fields.
